// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the cpu run controller and its dump FIFO.
package cpu_ctrl_pkg;

    localparam int LEN_W       = 8;
    localparam int IMEM_STRIDE = 4;
    localparam int DMEM_STRIDE = 8;
    localparam int FIFO_DEPTH  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_IMEM,
        ST_LD_DMEM,
        ST_RUN,
        ST_DUMP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dump_fifo.sv
// Two-entry 64-bit synchronous FIFO buffering DMEM read data toward the host dump stream.
module dump_fifo
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [63:0] push_data,
    output logic [63:0] head,
    output logic        full,
    output logic        empty
);

    logic [63:0] mem [FIFO_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        do_push;
    logic        do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = count == 2'(FIFO_DEPTH);
    assign empty   = count == 2'd0;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/cpu_run_controller.sv
// Host-side sequencer: load IMEM, load DMEM, run the core, dump a DMEM window.
// Defining CPU_CTRL_WATCHDOG_EN adds the run_cycles watchdog exit and the timeout flag.
//   state   | meaning
//   IDLE    | core in reset, waiting for start
//   LD_IMEM | streaming program words into IMEM
//   LD_DMEM | streaming initial data into DMEM
//   RUN     | core enabled until stop or watchdog
//   DUMP    | reading DMEM window out to the host
//   DONE    | status held until start or rst
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128,
    parameter int CYC_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] imem_len,
    input  logic [LEN_W-1:0] dmem_ld_len,
    input  logic [LEN_W-1:0] dmem_dump_len,
    input  logic [CYC_W-1:0] run_cycles,
    input  logic             stop,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic [63:0]      ld_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [63:0]      dump_data,
    output logic             cpu_arst_n,
    output logic             cpu_enable,
    output logic [63:0]      addr_ext,
    output logic             wen_ext,
    output logic             ren_ext,
    output logic [31:0]      wdata_ext,
    output logic [63:0]      addr_ext_2,
    output logic             wen_ext_2,
    output logic             ren_ext_2,
    output logic [63:0]      wdata_ext_2,
    input  logic [63:0]      rdata_ext_2,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CYC_W-1:0] cycle_count
);

    localparam logic [LEN_W-1:0] IMEM_MAX = LEN_W'(IMEM_WORDS);
    localparam logic [LEN_W-1:0] DMEM_MAX = LEN_W'(DMEM_WORDS);

    state_t           state, state_nx;
    logic [LEN_W-1:0] imem_len_q, dld_len_q, dump_len_q, idx, pop_cnt;
    logic [CYC_W-1:0] cycle_count_q;
    logic             timeout_q, rd_pend, wd_hit;
    logic             start_ok, in_load, ld_beat, ld_last, imem_beat, dmem_beat;
    logic             run_exit, rd_issue, pop, pop_last;
    logic             fifo_full, fifo_empty;
    logic [63:0]      fifo_head;
    logic [2:0]       occ_credit;

`ifdef CPU_CTRL_WATCHDOG_EN
    logic [CYC_W-1:0] run_cycles_q;

    always_ff @(posedge clk) begin
        if (rst) run_cycles_q <= '0;
        else if (start_ok) run_cycles_q <= run_cycles;
    end

    assign wd_hit = (run_cycles_q != '0) && (cycle_count_q + 1'b1 == run_cycles_q);
`else
    logic unused_run_cycles;
    assign unused_run_cycles = ^run_cycles;
    assign wd_hit = 1'b0;
`endif

    assign start_ok   = start && (state == ST_IDLE || state == ST_DONE);
    assign in_load    = state == ST_LD_IMEM || state == ST_LD_DMEM;
    assign ld_beat    = in_load && ld_valid;
    assign imem_beat  = ld_beat && state == ST_LD_IMEM;
    assign dmem_beat  = ld_beat && state == ST_LD_DMEM;
    assign ld_last    = (state == ST_LD_IMEM) ? (idx == imem_len_q - 1'b1)
                                              : (idx == dld_len_q - 1'b1);
    assign run_exit   = state == ST_RUN && (stop || wd_hit);
    assign pop        = dump_valid && dump_ready;
    assign pop_last   = pop && pop_cnt == dump_len_q - 1'b1;
    // A pop in the same cycle frees a slot; counting it sustains one word per cycle.
    assign occ_credit = {1'b0, fifo_full, !fifo_full && !fifo_empty} + {2'b0, rd_pend};
    assign rd_issue   = state == ST_DUMP && idx < dump_len_q && occ_credit < (3'd2 + {2'b0, pop});

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE, ST_DONE:
                if (start) begin
                    if (imem_len != '0)         state_nx = ST_LD_IMEM;
                    else if (dmem_ld_len != '0) state_nx = ST_LD_DMEM;
                    else                        state_nx = ST_RUN;
                end
            ST_LD_IMEM:
                if (ld_beat && ld_last) state_nx = (dld_len_q != '0) ? ST_LD_DMEM : ST_RUN;
            ST_LD_DMEM:
                if (ld_beat && ld_last) state_nx = ST_RUN;
            ST_RUN:
                if (run_exit) state_nx = (dump_len_q != '0) ? ST_DUMP : ST_DONE;
            ST_DUMP:
                if (pop_last) state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            imem_len_q    <= '0;
            dld_len_q     <= '0;
            dump_len_q    <= '0;
            idx           <= '0;
            pop_cnt       <= '0;
            rd_pend       <= 1'b0;
            cycle_count_q <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state   <= state_nx;
            rd_pend <= rd_issue;
            if (start_ok) begin
                imem_len_q    <= (imem_len > IMEM_MAX) ? IMEM_MAX : imem_len;
                dld_len_q     <= (dmem_ld_len > DMEM_MAX) ? DMEM_MAX : dmem_ld_len;
                dump_len_q    <= (dmem_dump_len > DMEM_MAX) ? DMEM_MAX : dmem_dump_len;
                idx           <= '0;
                pop_cnt       <= '0;
                cycle_count_q <= '0;
                timeout_q     <= 1'b0;
            end
            if (ld_beat)       idx <= ld_last ? '0 : idx + 1'b1;
            else if (rd_issue) idx <= idx + 1'b1;
            if (pop) pop_cnt <= pop_cnt + 1'b1;
            if (state == ST_RUN && cycle_count_q != '1) cycle_count_q <= cycle_count_q + 1'b1;
            if (run_exit && wd_hit) timeout_q <= 1'b1;
        end
    end

    dump_fifo u_dump_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rd_pend),
        .pop       (pop),
        .push_data (rdata_ext_2),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ld_ready    = in_load;
    assign wen_ext     = imem_beat && !rst;
    assign ren_ext     = 1'b0;
    assign addr_ext    = imem_beat ? 64'(idx) * 64'(IMEM_STRIDE) : '0;
    assign wdata_ext   = imem_beat ? ld_data[31:0] : '0;
    assign wen_ext_2   = dmem_beat && !rst;
    assign ren_ext_2   = rd_issue && !rst;
    assign addr_ext_2  = (dmem_beat || rd_issue) ? 64'(idx) * 64'(DMEM_STRIDE) : '0;
    assign wdata_ext_2 = dmem_beat ? ld_data : '0;
    assign cpu_arst_n  = !rst && (state == ST_RUN || state == ST_DUMP || state == ST_DONE);
    assign cpu_enable  = !rst && state == ST_RUN;
    assign dump_valid  = !fifo_empty;
    assign dump_data   = fifo_head;
    assign busy        = !(state == ST_IDLE || state == ST_DONE);
    assign done        = state == ST_DONE;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: load writes, run length, dump order and stalls, reset abort.
`timescale 1ns/1ps
module tb_cpu_run_controller;

`ifdef CPU_CTRL_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, start, stop, ld_valid, dump_ready;
    logic [7:0]  imem_len, dmem_ld_len, dmem_dump_len;
    logic [31:0] run_cycles;
    logic [63:0] ld_data;
    logic        ld_ready, dump_valid, cpu_arst_n, cpu_enable;
    logic [63:0] dump_data, addr_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] wdata_ext;
    logic [63:0] rdata_ext_2 = '0;
    logic        busy, done, timeout;
    logic [31:0] cycle_count;

    always #5 clk = ~clk;

    cpu_run_controller dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_len(imem_len), .dmem_ld_len(dmem_ld_len), .dmem_dump_len(dmem_dump_len),
        .run_cycles(run_cycles), .stop(stop),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
        .cpu_arst_n(cpu_arst_n), .cpu_enable(cpu_enable),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext), .wdata_ext(wdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    wr_t         imem_q[$];
    wr_t         dmem_q[$];
    logic [63:0] dump_q[$];
    logic [63:0] exp_mem [128];
    logic [63:0] dmem_m  [128];
    logic [127:0] dvld = '0;

    int n_vec = 0, n_err = 0;
    int cyc = 0, en_cnt = 0, act_cnt = 0, last_en_cyc = 0, first_dv_cyc = -1, last_pop_cyc = 0;
    logic first_en;

    function automatic logic [63:0] pat(input int a);
        return 64'hD00D_0000_0000_0000 + 64'(a);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // DMEM model: one-cycle read latency
    always @(posedge clk) begin
        if (wen_ext_2) begin
            dmem_m[addr_ext_2[9:3]] <= wdata_ext_2;
            dvld[addr_ext_2[9:3]]   <= 1'b1;
        end
        if (ren_ext_2)
            rdata_ext_2 <= dvld[addr_ext_2[9:3]] ? dmem_m[addr_ext_2[9:3]] : pat(int'(addr_ext_2[9:3]));
    end

    always @(negedge clk) begin : mon
        wr_t         e;
        logic [63:0] d;
        logic        prev_stall;
        logic [63:0] prev_data;
        cyc++;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (wen_ext) begin
                act_cnt++;
                chk("imem_write_expected", 64'(imem_q.size() != 0), 64'd1);
                if (imem_q.size() != 0) begin
                    e = imem_q.pop_front();
                    chk("imem_addr", addr_ext, e.addr);
                    chk("imem_data", 64'(wdata_ext), e.data);
                end
            end
            if (wen_ext_2) begin
                act_cnt++;
                chk("dmem_write_expected", 64'(dmem_q.size() != 0), 64'd1);
                if (dmem_q.size() != 0) begin
                    e = dmem_q.pop_front();
                    chk("dmem_addr", addr_ext_2, e.addr);
                    chk("dmem_data", wdata_ext_2, e.data);
                end
            end
            if (ren_ext_2 || ren_ext) act_cnt++;
            if (cpu_enable) begin
                en_cnt++;
                last_en_cyc = cyc;
            end
            if (dump_valid && first_dv_cyc < 0) first_dv_cyc = cyc;
            if (prev_stall) begin
                chk("stall_valid", 64'(dump_valid), 64'd1);
                chk("stall_data", dump_data, prev_data);
            end
            if (dump_valid && dump_ready) begin
                last_pop_cyc = cyc;
                chk("dump_expected", 64'(dump_q.size() != 0), 64'd1);
                if (dump_q.size() != 0) begin
                    d = dump_q.pop_front();
                    chk("dump_data", dump_data, d);
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_data  = dump_data;
        end
    end

    // One sequence: start, feed loads, pulse stop, apply ready pattern, wait for done.
    task automatic run_seq(input int ni, input int nd, input int ndump, input logic [31:0] rc,
                           input int stop_at, input logic [3:0] ld_pat,
                           input logic [7:0] rdy_pat, input int rdy_len, input int abort_pops);
        int beats = 0, p = 0, k = 0, r = 0, pops = 0, budget = 0;
        bit pushed = 0;
        en_cnt = 0; act_cnt = 0; first_dv_cyc = -1;
        @(posedge clk); #1;
        imem_len = 8'(ni); dmem_ld_len = 8'(nd); dmem_dump_len = 8'(ndump);
        run_cycles = rc; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        first_en = cpu_enable;
        while (!done && budget < 2000) begin
            if (beats < ni + nd) begin
                ld_valid = ld_pat[3 - (p % 4)];
                p++;
                ld_data = {$urandom, $urandom};
                if (ld_valid && ld_ready) begin
                    if (beats < ni) begin
                        imem_q.push_back('{64'(beats * 4), 64'(ld_data[31:0])});
                    end else begin
                        dmem_q.push_back('{64'((beats - ni) * 8), ld_data});
                        exp_mem[beats - ni] = ld_data;
                    end
                    beats++;
                end
            end else begin
                ld_valid = 1'b0;
            end
            if (cpu_enable) begin
                k++;
                if (!pushed) for (int i = 0; i < ndump; i++) dump_q.push_back(exp_mem[i]);
                pushed = 1;
            end
            stop = cpu_enable && stop_at != 0 && k == stop_at;
            if (dump_valid) begin
                dump_ready = (r < rdy_len) ? rdy_pat[rdy_len - 1 - r] : 1'b1;
                r++;
                if (dump_ready) pops++;
            end else begin
                dump_ready = 1'b1;
            end
            @(posedge clk); #1;
            budget++;
            if (abort_pops != 0 && pops >= abort_pops) break;
        end
        ld_valid = 1'b0;
        stop = 1'b0;
        if (abort_pops == 0) chk("done_reached", 64'(done), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; ld_valid = 1'b0; dump_ready = 1'b0;
        imem_len = '0; dmem_ld_len = '0; dmem_dump_len = '0; run_cycles = '0; ld_data = '0;
        for (int i = 0; i < 128; i++) exp_mem[i] = pat(i);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_arst_n", 64'(cpu_arst_n), 0);
        chk("rst_enable", 64'(cpu_enable), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_ld_ready", 64'(ld_ready), 0);
        chk("rst_dump_valid", 64'(dump_valid), 0);
        chk("rst_cycle_count", 64'(cycle_count), 0);
        chk("rst_addr_ext_2", addr_ext_2, 0);

        // load then limited run
        run_seq(3, 2, 0, 32'd10, WD ? 0 : 10, 4'b1111, 8'hFF, 0, 0);
        chk("t1_enabled_cycles", 64'(en_cnt), 10);
        chk("t1_cycle_count", 64'(cycle_count), 10);
        chk("t1_timeout", 64'(timeout), 64'(WD));
        chk("t1_writes", 64'(act_cnt), 5);
        chk("t1_busy", 64'(busy), 0);
        chk("t1_arst_n", 64'(cpu_arst_n), 1);

        // load stall
        run_seq(4, 0, 0, 32'd0, 2, 4'b1011, 8'hFF, 0, 0);
        chk("t2_writes", 64'(act_cnt), 4);
        chk("t2_imem_q_empty", 64'(imem_q.size()), 0);

        // dump backpressure
        run_seq(0, 4, 4, 32'd0, 2, 4'b1111, 8'b0010_0111, 6, 0);
        chk("t3_first_valid_latency", 64'(first_dv_cyc - last_en_cyc), 3);
        chk("t3_dump_q_empty", 64'(dump_q.size()), 0);

        // stop on RUN cycle 5, unlimited run
        run_seq(1, 0, 0, 32'd0, 5, 4'b1111, 8'hFF, 0, 0);
        chk("t4_cycle_count", 64'(cycle_count), 5);
        chk("t4_timeout", 64'(timeout), 0);
        chk("t4_enabled_cycles", 64'(en_cnt), 5);

        // stop and watchdog together
        run_seq(0, 0, 0, 32'd4, 4, 4'b1111, 8'hFF, 0, 0);
        chk("t5_enabled_cycles", 64'(en_cnt), 4);
        chk("t5_timeout", 64'(timeout), 64'(WD));

        // zero lengths
        run_seq(0, 0, 0, 32'd0, 3, 4'b1111, 8'hFF, 0, 0);
        chk("t6_straight_to_run", 64'(first_en), 1);
        chk("t6_port_activity", 64'(act_cnt), 0);
        chk("t6_enabled_cycles", 64'(en_cnt), 3);

        // reset mid-dump, then replay
        run_seq(2, 2, 4, 32'd0, 2, 4'b1111, 8'hFF, 0, 1);
        rst = 1'b1;
        dump_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        dump_q.delete();
        chk("abort_busy", 64'(busy), 0);
        chk("abort_arst_n", 64'(cpu_arst_n), 0);
        chk("abort_dump_valid", 64'(dump_valid), 0);
        chk("abort_ren_2", 64'(ren_ext_2), 0);
        chk("abort_cycle_count", 64'(cycle_count), 0);
        chk("abort_done", 64'(done), 0);
        run_seq(2, 2, 3, 32'd0, 3, 4'b1111, 8'hFF, 0, 0);
        chk("t7_dump_throughput", 64'(last_pop_cyc - first_dv_cyc), 2);
        chk("t7_dump_q_empty", 64'(dump_q.size()), 0);
        chk("t7_cycle_count", 64'(cycle_count), 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Host-side sequencer that wraps the `cpu` top and drives its external memory ports and `enable`. In order, it streams a program into instruction memory, then initial data into data memory, runs the core, and streams a window of data memory back to the host. It sits between the testbench/host link and `cpu`. It owns the core's `arst_n` and `enable`, plus both `*_ext` port sets.

## Interface
Parameters:
- `IMEM_WORDS`, 128 — instruction memory depth in 32-bit words.
- `DMEM_WORDS`, 128 — data memory depth in 64-bit words.
- `CYC_W`, 32 — cycle counter width.

Ports:
- `clk` in 1 — clock. One clock; reset is synchronous and active-high.
- `rst` in 1 — synchronous active-high reset.
- `start` in 1 — pulse that begins a sequence; honoured only in IDLE or DONE.
- `imem_len` in 8 — instruction words to load, 0..`IMEM_WORDS`.
- `dmem_ld_len` in 8 — data words to load, 0..`DMEM_WORDS`.
- `dmem_dump_len` in 8 — data words to dump, 0..`DMEM_WORDS`.
- `run_cycles` in `CYC_W` — watchdog limit; 0 means unlimited.
- `stop` in 1 — host halt request; honoured in RUN.
- `ld_valid` in 1, `ld_ready` out 1, `ld_data` in 64 — load stream. IMEM uses `ld_data[31:0]`.
- `dump_valid` out 1, `dump_ready` in 1, `dump_data` out 64 — dump stream.
- `cpu_arst_n` out 1, `cpu_enable` out 1 — drive the core.
- `addr_ext` out 64, `wen_ext` out 1, `ren_ext` out 1, `wdata_ext` out 32 — IMEM external port.
- `addr_ext_2` out 64, `wen_ext_2` out 1, `ren_ext_2` out 1, `wdata_ext_2` out 64, `rdata_ext_2` in 64 — DMEM external port.
- `busy` out 1, `done` out 1, `timeout` out 1, `cycle_count` out `CYC_W` — status.

## Operation
- FSM states: IDLE, LD_IMEM, LD_DMEM, RUN, DUMP, DONE.
- `start` loads all length inputs and `run_cycles` into registers. It clears `done`, `timeout` and `cycle_count`. The next state is the first state whose length is nonzero (LD_IMEM → LD_DMEM → RUN). RUN is always entered.
- LD_IMEM:
  - `ld_ready`=1.
  - Each `ld_valid&&ld_ready` beat drives `wen_ext`=1, `addr_ext`=idx*4 and `wdata_ext`=`ld_data[31:0]` combinationally in that cycle.
  - After beat `imem_len`-1 the FSM leaves the state.
- LD_DMEM: same as LD_IMEM, using `wen_ext_2` and `addr_ext_2`=idx*8.
- `cpu_arst_n`=0 in IDLE, LD_IMEM and LD_DMEM. It is 1 in RUN, DUMP and DONE.
- RUN:
  - `cpu_enable`=1 and `cycle_count` increments every cycle, saturating at all-ones.
  - The FSM exits to DUMP (or to DONE if `dmem_dump_len`=0) on `stop`, or on the watchdog condition (see Configuration).
  - The exit cycle is itself enabled. `cpu_enable` is 0 from the next cycle. In-flight instructions freeze and are not drained.
- DUMP:
  - Issues `ren_ext_2` with `addr_ext_2`=idx*8. Read data returns on `rdata_ext_2` one cycle later and is pushed into a 2-entry FIFO.
  - A read issues only when (FIFO occupancy + outstanding reads) < 2, so the FIFO never overflows.
  - `dump_valid` = FIFO not empty; `dump_data` = FIFO head.
  - The FSM goes to DONE when all `dmem_dump_len` words have been popped.
- DONE: `done`=1 and status outputs are held until `start` or `rst`.
- `busy`=1 in every state except IDLE and DONE.
- `stop` outside RUN is ignored. `start` outside IDLE/DONE is ignored.
- Unused external-port outputs are 0 in every state.

## Timing
- Reset values:
  - FSM = IDLE; `cpu_arst_n`=0.
  - `cpu_enable`, `ld_ready`, `dump_valid`, `busy`, `done` and `timeout` = 0.
  - `cycle_count`=0; all address, data and enable outputs = 0; FIFO is empty.
- `rst` mid-sequence aborts immediately: FIFO flushed, core held in reset. No partial write occurs in the `rst` cycle because memory write enables are gated by `!rst`.
- Load throughput is 1 word/cycle. Each write occurs in the same cycle as its handshake.
- Dump throughput is 1 word/cycle with `dump_ready` held high. The first `dump_valid` appears 2 cycles after DUMP entry.
- `dump_valid`/`dump_data` stay stable while `dump_ready`=0.
- Simultaneous `stop` and watchdog in the same cycle: one exit, and `timeout`=1.

## Configuration
- `CPU_CTRL_WATCHDOG_EN` defined:
  - RUN also exits when `cycle_count`+1 == `run_cycles` (`run_cycles`≠0). That gives exactly `run_cycles` enabled cycles.
  - `timeout` is set on that exit.
- Undefined: `run_cycles` is ignored, `timeout` is tied to 0, and only `stop` ends RUN.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - `IMEM_STRIDE`=4 and `DMEM_STRIDE`=8;
  - `LEN_W`=8;
  - `FIFO_DEPTH`=2.
- One sub-module: `dump_fifo`, a 2-entry 64-bit synchronous FIFO with push/pop, full and empty.

## Test plan
- Load and limit run: `imem_len`=3, `dmem_ld_len`=2, watchdog on, `run_cycles`=10, `dmem_dump_len`=0 → IMEM writes at addresses 0,4,8, DMEM writes at 0,8, then `cpu_enable` high exactly 10 cycles, then `done`=1 and `timeout`=1.
- Load stall: `ld_valid` toggling 1,0,1,1 → `wen_ext` pulses only on valid cycles and addresses stay contiguous.
- Dump backpressure: `dmem_dump_len`=4 with `dump_ready` pattern 1,0,0,1,1,1 → 4 words popped in address order 0,8,16,24, none dropped or duplicated, `dump_data` stable while stalled.
- Stop: `stop` pulse on RUN cycle 5, `run_cycles`=0 → `cycle_count`=5, `timeout`=0.
- Zero lengths: all lengths 0 → IDLE→RUN; `stop` → DONE with no memory port activity.
- Reset mid-DUMP after 1 word popped → all outputs return to reset values next cycle; `start` then replays the full sequence.
